// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetch-stage FSM encoding.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_000C;
   localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   // Instruction memory is word addressed, so byte offsets are always cleared.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble (flush) beats hold, hold beats load.
// Same hold/flush pattern is intended for reuse at ID/EX.
module if_id_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] instr_d,
   input  logic [31:0] pcplus4_d,
   output logic [31:0] instr_q,
   output logic [31:0] pcplus4_q,
   output logic        valid_q
);

   // Pipeline register with synchronous reset and bubble-over-hold priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q   <= NOP_WORD;
         pcplus4_q <= 32'h0000_0000;
         valid_q   <= 1'b0;
      end else if (flush) begin
         instr_q   <= NOP_WORD;
         pcplus4_q <= 32'h0000_0000;
         valid_q   <= 1'b0;
      end else if (hold) begin
         instr_q   <= instr_q;
         pcplus4_q <= pcplus4_q;
         valid_q   <= valid_q;
      end else begin
         instr_q   <= instr_d;
         pcplus4_q <= pcplus4_d;
         valid_q   <= 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, RUN/HALTED FSM and IF/ID register.
// Optional FETCH_PERF_EN adds FetchCount/BubbleCount performance counters.
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] Address,
   output logic [31:0] IfId_Instruction,
   output logic [31:0] IfId_PCPlus4,
   output logic        IfId_Valid,
   output logic        Halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] BubbleCount
`endif
);

   logic [31:0]  pc_r;
   logic [31:0]  pc_next_s;
   logic [31:0]  pc_plus4_s;
   fetch_state_e state_r;
   fetch_state_e state_next_s;
   logic         bubble_s;
   logic         hold_s;
   logic         load_s;

   assign pc_plus4_s = pc_r + 32'd4;
   assign bubble_s   = Redirect | Flush;
   assign hold_s     = Stall | (state_r == HALTED);
   assign load_s     = ~bubble_s & ~hold_s;

   // Next PC: redirect beats hold (stall or halted), hold beats sequential fetch.
   always_comb begin
      pc_next_s = pc_plus4_s;
      if (Redirect) begin
         pc_next_s = word_align(RedirectTarget);
      end else if (hold_s) begin
         pc_next_s = pc_r;
      end else begin
         pc_next_s = pc_plus4_s;
      end
   end

   // Halting only on a real load keeps a held SYSCALL from re-triggering.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         RUN: begin
            if (load_s && (Instruction == HALT_WORD)) begin
               state_next_s = HALTED;
            end else begin
               state_next_s = RUN;
            end
         end
         HALTED: begin
            if (bubble_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = HALTED;
            end
         end
         default: state_next_s = RUN;
      endcase
   end

   // PC and FSM state registers.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         pc_r    <= RESET_PC;
         state_r <= RUN;
      end else begin
         pc_r    <= pc_next_s;
         state_r <= state_next_s;
      end
   end

   assign Address = pc_r;
   assign Halted  = (state_r == HALTED);

   if_id_reg u_if_id_reg (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .hold      (hold_s),
      .flush     (bubble_s),
      .instr_d   (Instruction),
      .pcplus4_d (pc_plus4_s),
      .instr_q   (IfId_Instruction),
      .pcplus4_q (IfId_PCPlus4),
      .valid_q   (IfId_Valid)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_r;
   logic [31:0] bubble_count_r;

   // Counters wrap naturally; neither advances on a hold edge.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         fetch_count_r  <= 32'h0000_0000;
         bubble_count_r <= 32'h0000_0000;
      end else begin
         fetch_count_r  <= load_s   ? fetch_count_r + 32'd1  : fetch_count_r;
         bubble_count_r <= bubble_s ? bubble_count_r + 32'd1 : bubble_count_r;
      end
   end

   assign FetchCount  = fetch_count_r;
   assign BubbleCount = bubble_count_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a reference model pushes expected
// outputs to a queue per driven cycle; each test task pops and compares.
module tb_if_fetch_stage;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pcp4;
      logic        valid;
      logic        halted;
   } obs_t;

   typedef struct packed {
      logic        rst;
      logic        st;
      logic        fl;
      logic        rd;
      logic [31:0] tgt;
   } stim_t;

   localparam logic [31:0] HALT = 32'h0000_000C;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Stall;
   logic        Flush;
   logic        Redirect;
   logic [31:0] RedirectTarget;
   logic [31:0] Instruction;
   logic [31:0] Address;
   logic [31:0] IfId_Instruction;
   logic [31:0] IfId_PCPlus4;
   logic        IfId_Valid;
   logic        Halted;
`ifdef FETCH_PERF_EN
   logic [31:0] FetchCount;
   logic [31:0] BubbleCount;
`endif

   logic [31:0] mem [0:63];
   obs_t        exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_pcp4, m_fetch, m_bubble;
   logic        m_valid, m_halted;

   always #5 Clk = ~Clk;

   assign Instruction = mem[Address[7:2]];

   if_fetch_stage dut (
      .Clk              (Clk),
      .Rst_n            (Rst_n),
      .Stall            (Stall),
      .Flush            (Flush),
      .Redirect         (Redirect),
      .RedirectTarget   (RedirectTarget),
      .Instruction      (Instruction),
      .Address          (Address),
      .IfId_Instruction (IfId_Instruction),
      .IfId_PCPlus4     (IfId_PCPlus4),
      .IfId_Valid       (IfId_Valid),
      .Halted           (Halted)
`ifdef FETCH_PERF_EN
      ,
      .FetchCount       (FetchCount),
      .BubbleCount      (BubbleCount)
`endif
   );

   task automatic drive_cycle(input stim_t s);
      obs_t        e;
      logic [31:0] word;
      logic        bub, hold;
      Rst_n          = s.rst;
      Stall          = s.st;
      Flush          = s.fl;
      Redirect       = s.rd;
      RedirectTarget = s.tgt;
      if (!s.rst) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
         m_halted = 1'b0; m_fetch = 32'h0; m_bubble = 32'h0;
      end else begin
         bub  = s.rd | s.fl;
         hold = s.st | m_halted;
         word = mem[m_pc[7:2]];
         if (bub) begin
            m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
            m_bubble = m_bubble + 32'd1;
            if (m_halted) m_halted = 1'b0;
         end else if (!hold) begin
            m_instr = word; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_fetch = m_fetch + 32'd1;
            if (word == HALT) m_halted = 1'b1;
         end
         if (s.rd)       m_pc = {s.tgt[31:2], 2'b00};
         else if (!hold) m_pc = m_pc + 32'd4;
      end
      e = {m_pc, m_instr, m_pcp4, m_valid, m_halted};
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   function automatic stim_t run();
      return {1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
   endfunction
   function automatic stim_t st();
      return {1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
   endfunction
   function automatic stim_t fl();
      return {1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
   endfunction
   function automatic stim_t rs();
      return {1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
   endfunction
   function automatic stim_t rd(input logic stall, input logic [31:0] t);
      return {1'b1, stall, 1'b0, 1'b1, t};
   endfunction

   task automatic test_reset();
      stim_t tbl [2];
      obs_t  e, o;
      tbl = '{rs(), rs()};
      foreach (tbl[i]) begin
         drive_cycle(tbl[i]);
         e = exp_q.pop_front();
         o = {Address, IfId_Instruction, IfId_PCPlus4, IfId_Valid, Halted};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %h required %h", i, o, e);
         end
      end
      n_checks++;
      if (Address !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h required 00000000", Address);
      end
   endtask

   task automatic test_run();
      stim_t tbl [2];
      obs_t  e, o;
      tbl = '{run(), run()};
      foreach (tbl[i]) begin
         drive_cycle(tbl[i]);
         e = exp_q.pop_front();
         o = {Address, IfId_Instruction, IfId_PCPlus4, IfId_Valid, Halted};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL run[%0d]: got %h required %h", i, o, e);
         end
      end
      n_checks++;
      if ({IfId_Instruction, IfId_PCPlus4, IfId_Valid} !== {32'd3, 32'd8, 1'b1}) begin
         n_fail++;
         $display("FAIL run_second: got %h/%h/%b required 3/8/1",
                  IfId_Instruction, IfId_PCPlus4, IfId_Valid);
      end
   endtask

   task automatic test_stall();
      stim_t tbl [3];
      obs_t  e, o;
      tbl = '{st(), st(), run()};
      foreach (tbl[i]) begin
         drive_cycle(tbl[i]);
         e = exp_q.pop_front();
         o = {Address, IfId_Instruction, IfId_PCPlus4, IfId_Valid, Halted};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stall[%0d]: got %h required %h", i, o, e);
         end
      end
      n_checks++;
      if ({IfId_Instruction, IfId_PCPlus4} !== {32'd6, 32'd12}) begin
         n_fail++;
         $display("FAIL stall_release: got %h/%h required 6/12", IfId_Instruction, IfId_PCPlus4);
      end
   endtask

   task automatic test_redirect_stall();
      stim_t tbl [2];
      obs_t  e, o;
      tbl = '{rd(1'b1, 32'h0000_0042), run()};
      foreach (tbl[i]) begin
         drive_cycle(tbl[i]);
         e = exp_q.pop_front();
         o = {Address, IfId_Instruction, IfId_PCPlus4, IfId_Valid, Halted};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL redirect_stall[%0d]: got %h required %h", i, o, e);
         end
      end
      n_checks++;
      if ({IfId_Instruction, IfId_PCPlus4, IfId_Valid} !== {32'd48, 32'h44, 1'b1}) begin
         n_fail++;
         $display("FAIL redirect_load: got %h/%h/%b required 30/44/1",
                  IfId_Instruction, IfId_PCPlus4, IfId_Valid);
      end
   endtask

   // flush at PC=12, flush+stall (bubble, PC holds), then reset mid-stream
   task automatic test_flush_reset();
      stim_t tbl [10];
      obs_t  e, o;
      tbl = '{rs(), run(), run(), run(), fl(), run(),
              {1'b1, 1'b1, 1'b1, 1'b0, 32'h0}, run(), run(), rs()};
      foreach (tbl[i]) begin
         drive_cycle(tbl[i]);
         e = exp_q.pop_front();
         o = {Address, IfId_Instruction, IfId_PCPlus4, IfId_Valid, Halted};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL flush_reset[%0d]: got %h required %h", i, o, e);
         end
      end
   endtask

   task automatic test_halt();
      stim_t tbl [28];
      obs_t  e, o;
      tbl = '{run(), run(), run(), run(), run(), run(),
              run(), st(), run(), run(), st(), st(), run(), run(), run(), run(),
              rd(1'b0, 32'h8), run(), run(), run(), run(), run(), run(),
              {1'b1, 1'b1, 1'b1, 1'b0, 32'h0}, run(), run(), run(), run()};
      foreach (tbl[i]) begin
         drive_cycle(tbl[i]);
         e = exp_q.pop_front();
         o = {Address, IfId_Instruction, IfId_PCPlus4, IfId_Valid, Halted};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL halt[%0d]: got %h required %h", i, o, e);
         end
         if (i == 15) begin
            n_checks++;
            if ({Address, Halted, IfId_Instruction} !== {32'd24, 1'b1, HALT}) begin
               n_fail++;
               $display("FAIL halt_frozen: got %h/%b/%h required 18/1/c",
                        Address, Halted, IfId_Instruction);
            end
         end
      end
   endtask

   task automatic test_wrap();
      stim_t tbl [3];
      obs_t  e, o;
      tbl = '{rd(1'b0, 32'hFFFF_FFFE), run(), run()};
      foreach (tbl[i]) begin
         drive_cycle(tbl[i]);
         e = exp_q.pop_front();
         o = {Address, IfId_Instruction, IfId_PCPlus4, IfId_Valid, Halted};
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got %h required %h", i, o, e);
         end
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      stim_t tbl [9];
      obs_t  e;
      tbl = '{rs(), run(), run(), run(), run(), run(), fl(), st(), st()};
      foreach (tbl[i]) begin
         drive_cycle(tbl[i]);
         e = exp_q.pop_front();
         n_checks++;
         if ({FetchCount, BubbleCount} !== {m_fetch, m_bubble}) begin
            n_fail++;
            $display("FAIL perf[%0d]: got %0d/%0d required %0d/%0d",
                     i, FetchCount, BubbleCount, m_fetch, m_bubble);
         end
      end
      n_checks++;
      if ({FetchCount, BubbleCount} !== {32'd5, 32'd1}) begin
         n_fail++;
         $display("FAIL perf_final: got %0d/%0d required 5/1", FetchCount, BubbleCount);
      end
   endtask
`endif

   initial begin
      // mem[i]=i*3, except mem[4] would equal the halt word, so it is replaced
      for (int i = 0; i < 64; i++) mem[i] = i * 3;
      mem[4] = 32'h0000_1234;
      mem[5] = HALT;
      Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0;
      RedirectTarget = 32'h0;
      test_reset();
      test_run();
      test_stall();
      test_redirect_stall();
      test_flush_reset();
      test_halt();
      test_wrap();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
